// File: rtl/ace_snoop_initiator.sv
// ACE snoop initiator: issues one AC snoop, collects the CR response and an optional CD line,
// and reports the response, the AC-to-CR latency and timeout/protocol error flags.
module ace_snoop_initiator #(
    parameter int C_ACE_DATA_WIDTH = 128,
    parameter int C_ACE_ADDR_WIDTH = 44,
    parameter int C_LINE_BEATS     = 4,
    parameter int C_CNT_WIDTH      = 32
) (
    input  logic                                       ace_aclk,
    input  logic                                       ace_areset,
    input  logic                                       i_start,
    input  logic [C_ACE_ADDR_WIDTH-1:0]                i_acaddr,
    input  logic [3:0]                                 i_acsnoop,
    input  logic [C_CNT_WIDTH-1:0]                     i_timeout_reg,
    output logic                                       o_acvalid,
    output logic [C_ACE_ADDR_WIDTH-1:0]                o_acaddr,
    output logic [3:0]                                 o_acsnoop,
    output logic [2:0]                                 o_acprot,
    input  logic                                       i_acready,
    input  logic                                       i_crvalid,
    input  logic [4:0]                                 i_crresp,
    output logic                                       o_crready,
    input  logic                                       i_cdvalid,
    input  logic [C_ACE_DATA_WIDTH-1:0]                i_cddata,
    input  logic                                       i_cdlast,
    output logic                                       o_cdready,
    output logic                                       o_busy,
    output logic                                       o_done,
    output logic [4:0]                                 o_crresp,
    output logic [C_ACE_DATA_WIDTH*C_LINE_BEATS-1:0]   o_line_data,
    output logic [$clog2(C_LINE_BEATS):0]              o_beats,
    output logic [C_CNT_WIDTH-1:0]                     o_latency,
    output logic [2:0]                                 o_error
);

    localparam int C_BEAT_W = $clog2(C_LINE_BEATS) + 1;
    localparam logic [C_BEAT_W-1:0] C_LAST_SLOT = C_BEAT_W'(C_LINE_BEATS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_AC_REQ,
        S_CR_WAIT,
        S_CD_WAIT,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_next;

    logic                                     r_acValid;
    logic                                     r_crReady;
    logic                                     r_cdReady;
    logic                                     r_busy;
    logic                                     r_done;
    logic [C_ACE_ADDR_WIDTH-1:0]              r_acAddr;
    logic [3:0]                               r_acSnoop;
    logic [4:0]                               r_crResp;
    logic [C_ACE_DATA_WIDTH*C_LINE_BEATS-1:0] r_lineData;
    logic [C_BEAT_W-1:0]                      r_beats;
    logic [C_CNT_WIDTH-1:0]                   r_latency;
    logic [2:0]                               r_error;
    logic [C_CNT_WIDTH-1:0]                   r_toCnt;

    logic w_acHs;
    logic w_crHs;
    logic w_cdHs;
    logic w_lastSlot;
    logic w_toHit;

    assign w_acHs     = (r_state == S_AC_REQ)  && i_acready;
    assign w_crHs     = (r_state == S_CR_WAIT) && i_crvalid;
    assign w_cdHs     = (r_state == S_CD_WAIT) && i_cdvalid;
    assign w_lastSlot = (r_beats == C_LAST_SLOT);
    // Timeout fires in the cycle whose count would reach the programmed limit.
    assign w_toHit    = (i_timeout_reg != '0) &&
                        ((r_toCnt + C_CNT_WIDTH'(1)) >= i_timeout_reg);

    always_ff @(posedge ace_aclk) begin
        if (ace_areset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_next = S_AC_REQ;
                end
            end
            S_AC_REQ: begin
                if (w_acHs) begin
                    w_next = S_CR_WAIT;
                end
            end
            S_CR_WAIT: begin
                if (w_crHs) begin
                    w_next = i_crresp[0] ? S_CD_WAIT : S_DONE;
                end else if (w_toHit) begin
                    w_next = S_DONE;
                end
            end
            S_CD_WAIT: begin
                if (w_cdHs) begin
                    if (i_cdlast || w_lastSlot) begin
                        w_next = S_DONE;
                    end
                end else if (w_toHit) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Handshake outputs are registered from the next state so they line up with the state.
    always_ff @(posedge ace_aclk) begin
        if (ace_areset) begin
            r_acValid  <= 1'b0;
            r_crReady  <= 1'b0;
            r_cdReady  <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_acAddr   <= '0;
            r_acSnoop  <= '0;
            r_crResp   <= '0;
            r_lineData <= '0;
            r_beats    <= '0;
            r_latency  <= '0;
            r_error    <= '0;
            r_toCnt    <= '0;
        end else begin
            r_acValid <= (w_next == S_AC_REQ);
            r_crReady <= (w_next == S_CR_WAIT);
            r_cdReady <= (w_next == S_CD_WAIT);
            r_busy    <= (w_next != S_IDLE);
            r_done    <= (w_next == S_DONE);

            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_acAddr   <= i_acaddr;
                        r_acSnoop  <= i_acsnoop;
                        r_error    <= '0;
                        r_beats    <= '0;
                        r_lineData <= '0;
                        r_latency  <= '0;
                    end
                end
                S_AC_REQ: begin
                    r_toCnt <= '0;
                    if (r_latency != '1) begin
                        r_latency <= r_latency + C_CNT_WIDTH'(1);
                    end
                end
                S_CR_WAIT: begin
                    if (r_latency != '1) begin
                        r_latency <= r_latency + C_CNT_WIDTH'(1);
                    end
                    if (r_toCnt != '1) begin
                        r_toCnt <= r_toCnt + C_CNT_WIDTH'(1);
                    end
                    if (w_crHs) begin
                        r_crResp <= i_crresp;
                    end else if (w_toHit) begin
                        r_error[0] <= 1'b1;
                    end
                end
                S_CD_WAIT: begin
                    if (r_toCnt != '1) begin
                        r_toCnt <= r_toCnt + C_CNT_WIDTH'(1);
                    end
                    if (w_cdHs) begin
                        for (int k = 0; k < C_LINE_BEATS; k++) begin
                            if (r_beats == C_BEAT_W'(k)) begin
                                r_lineData[k*C_ACE_DATA_WIDTH +: C_ACE_DATA_WIDTH] <= i_cddata;
                            end
                        end
                        r_beats <= r_beats + C_BEAT_W'(1);
                        if (i_cdlast && !w_lastSlot) begin
                            r_error[1] <= 1'b1;
                        end
                        if (!i_cdlast && w_lastSlot) begin
                            r_error[2] <= 1'b1;
                        end
                    end else if (w_toHit) begin
                        r_error[0] <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign o_acvalid   = r_acValid;
    assign o_acaddr    = r_acAddr;
    assign o_acsnoop   = r_acSnoop;
    assign o_acprot    = 3'b000;
    assign o_crready   = r_crReady;
    assign o_cdready   = r_cdReady;
    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_crresp    = r_crResp;
    assign o_line_data = r_lineData;
    assign o_beats     = r_beats;
    assign o_latency   = r_latency;
    assign o_error     = r_error;

endmodule

// File: tb/tb_ace_snoop_initiator.sv
// Directed bench for ace_snoop_initiator: stimulus tasks push expected results into a queue,
// and a monitor pops and compares them whenever the DUT pulses o_done.
module tb_ace_snoop_initiator;

    logic         ace_aclk = 1'b0;
    logic         ace_areset;
    logic         i_start;
    logic [43:0]  i_acaddr;
    logic [3:0]   i_acsnoop;
    logic [31:0]  i_timeout_reg;
    logic         o_acvalid;
    logic [43:0]  o_acaddr;
    logic [3:0]   o_acsnoop;
    logic [2:0]   o_acprot;
    logic         i_acready;
    logic         i_crvalid;
    logic [4:0]   i_crresp;
    logic         o_crready;
    logic         i_cdvalid;
    logic [127:0] i_cddata;
    logic         i_cdlast;
    logic         o_cdready;
    logic         o_busy;
    logic         o_done;
    logic [4:0]   o_crresp;
    logic [511:0] o_line_data;
    logic [2:0]   o_beats;
    logic [31:0]  o_latency;
    logic [2:0]   o_error;

    ace_snoop_initiator dut (
        .ace_aclk      (ace_aclk),
        .ace_areset    (ace_areset),
        .i_start       (i_start),
        .i_acaddr      (i_acaddr),
        .i_acsnoop     (i_acsnoop),
        .i_timeout_reg (i_timeout_reg),
        .o_acvalid     (o_acvalid),
        .o_acaddr      (o_acaddr),
        .o_acsnoop     (o_acsnoop),
        .o_acprot      (o_acprot),
        .i_acready     (i_acready),
        .i_crvalid     (i_crvalid),
        .i_crresp      (i_crresp),
        .o_crready     (o_crready),
        .i_cdvalid     (i_cdvalid),
        .i_cddata      (i_cddata),
        .i_cdlast      (i_cdlast),
        .o_cdready     (o_cdready),
        .o_busy        (o_busy),
        .o_done        (o_done),
        .o_crresp      (o_crresp),
        .o_line_data   (o_line_data),
        .o_beats       (o_beats),
        .o_latency     (o_latency),
        .o_error       (o_error)
    );

    always #5 ace_aclk = ~ace_aclk;

    typedef struct {
        logic [4:0]   crResp;
        bit           chkCr;
        logic [2:0]   beats;
        logic [511:0] line;
        logic [31:0]  latency;
        bit           chkLat;
        logic [2:0]   error;
    } exp_t;

    typedef struct {
        logic [43:0] addr;
        logic [3:0]  snoop;
        logic [31:0] toReg;
        int          acWait;
        int          crDelay;
        logic [4:0]  crResp;
        int          nBeats;
        int          lastIdx;
        bit          gap;
    } vec_t;

    exp_t expQ[$];
    exp_t expCur;
    int   nChecks = 0;
    int   nErrors = 0;

    task automatic checkOutput(input string name, input logic [511:0] act, input logic [511:0] exp);
        nChecks++;
        if (act !== exp) begin
            nErrors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] beatData(input int b);
        logic [3:0] n;
        n = 4'hA + 4'(b);
        return {32{n}};
    endfunction

    function automatic void pushExp(input logic [4:0] cr, input bit chkCr, input logic [2:0] beats,
                                    input logic [511:0] line, input logic [31:0] lat,
                                    input bit chkLat, input logic [2:0] err);
        exp_t e;
        e.crResp  = cr;
        e.chkCr   = chkCr;
        e.beats   = beats;
        e.line    = line;
        e.latency = lat;
        e.chkLat  = chkLat;
        e.error   = err;
        expQ.push_back(e);
    endfunction

    // Monitor: every completion pulse is matched against the oldest expected result.
    always @(negedge ace_aclk) begin
        if (!ace_areset && o_done) begin
            if (expQ.size() == 0) begin
                checkOutput("spuriousDone", 512'(o_done), 512'(0));
            end else begin
                expCur = expQ.pop_front();
                checkOutput("doneBusy", 512'(o_busy), 512'(1));
                checkOutput("beats", 512'(o_beats), 512'(expCur.beats));
                checkOutput("line", o_line_data, expCur.line);
                checkOutput("error", 512'(o_error), 512'(expCur.error));
                if (expCur.chkCr) begin
                    checkOutput("crresp", 512'(o_crresp), 512'(expCur.crResp));
                end
                if (expCur.chkLat) begin
                    checkOutput("latency", 512'(o_latency), 512'(expCur.latency));
                end
            end
        end
    end

    task automatic tick();
        @(posedge ace_aclk);
        #1;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_acvalid"}, 512'(o_acvalid), 512'(0));
        checkOutput({tag, "_acaddr"}, 512'(o_acaddr), 512'(0));
        checkOutput({tag, "_acsnoop"}, 512'(o_acsnoop), 512'(0));
        checkOutput({tag, "_acprot"}, 512'(o_acprot), 512'(0));
        checkOutput({tag, "_crready"}, 512'(o_crready), 512'(0));
        checkOutput({tag, "_cdready"}, 512'(o_cdready), 512'(0));
        checkOutput({tag, "_busy"}, 512'(o_busy), 512'(0));
        checkOutput({tag, "_done"}, 512'(o_done), 512'(0));
        checkOutput({tag, "_crresp"}, 512'(o_crresp), 512'(0));
        checkOutput({tag, "_line"}, o_line_data, 512'(0));
        checkOutput({tag, "_beats"}, 512'(o_beats), 512'(0));
        checkOutput({tag, "_latency"}, 512'(o_latency), 512'(0));
        checkOutput({tag, "_error"}, 512'(o_error), 512'(0));
    endtask

    task automatic startSnoop(input logic [43:0] addr, input logic [3:0] snoop);
        checkOutput("acvalidBeforeStart", 512'(o_acvalid), 512'(0));
        i_start   = 1'b1;
        i_acaddr  = addr;
        i_acsnoop = snoop;
        tick();
        i_start   = 1'b0;
        i_acaddr  = ~addr;
        i_acsnoop = ~snoop;
        checkOutput("acvalidAfterStart", 512'(o_acvalid), 512'(1));
        checkOutput("acaddr", 512'(o_acaddr), 512'(addr));
        checkOutput("acsnoop", 512'(o_acsnoop), 512'(snoop));
        checkOutput("busy", 512'(o_busy), 512'(1));
    endtask

    task automatic waitIdle();
        for (int i = 0; i < 40; i++) begin
            if (!o_busy) break;
            tick();
        end
        checkOutput("idleReached", 512'(o_busy), 512'(0));
        checkOutput("doneSeen", 512'(expQ.size()), 512'(0));
    endtask

    task automatic applyStimulus(input vec_t v);
        i_timeout_reg = v.toReg;
        i_acready     = 1'b0;
        startSnoop(v.addr, v.snoop);
        for (int i = 0; i < v.acWait; i++) begin
            tick();
            checkOutput("bpAcvalid", 512'(o_acvalid), 512'(1));
            checkOutput("bpAcaddr", 512'(o_acaddr), 512'(v.addr));
            checkOutput("bpAcsnoop", 512'(o_acsnoop), 512'(v.snoop));
        end
        i_acready = 1'b1;
        tick();
        i_acready = 1'b0;
        checkOutput("acvalidDropped", 512'(o_acvalid), 512'(0));
        checkOutput("crreadyUp", 512'(o_crready), 512'(1));
        if (v.crDelay < 0) begin
            repeat (v.toReg - 1) tick();
            checkOutput("crreadyBeforeTimeout", 512'(o_crready), 512'(1));
            tick();
            checkOutput("timeoutDone", 512'(o_done), 512'(1));
            checkOutput("timeoutCrready", 512'(o_crready), 512'(0));
        end else begin
            repeat (v.crDelay) tick();
            i_crvalid = 1'b1;
            i_crresp  = v.crResp;
            tick();
            i_crvalid = 1'b0;
            if (v.crResp[0]) begin
                for (int b = 0; b < v.nBeats; b++) begin
                    if (v.gap && b > 0) begin
                        i_cdvalid = 1'b0;
                        tick();
                    end
                    i_cdvalid = 1'b1;
                    i_cddata  = beatData(b);
                    i_cdlast  = (b == v.lastIdx);
                    tick();
                end
                i_cdvalid = 1'b0;
                i_cdlast  = 1'b0;
            end
        end
        waitIdle();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t v;
        logic [511:0] fullLine;
        logic [511:0] halfLine;
        fullLine = {beatData(3), beatData(2), beatData(1), beatData(0)};
        halfLine = {256'h0, beatData(1), beatData(0)};

        ace_areset    = 1'b1;
        i_start       = 1'b0;
        i_acaddr      = '0;
        i_acsnoop     = '0;
        i_timeout_reg = '0;
        i_acready     = 1'b0;
        i_crvalid     = 1'b0;
        i_crresp      = '0;
        i_cdvalid     = 1'b0;
        i_cddata      = '0;
        i_cdlast      = 1'b0;
        repeat (3) tick();
        ace_areset = 1'b0;
        checkAllZero("reset");

        // Clean snoop, no data: CR three cycles after the AC handshake.
        v = '{addr:44'h1000, snoop:4'b0001, toReg:32'd0, acWait:0, crDelay:2,
              crResp:5'b01000, nBeats:0, lastIdx:-1, gap:1'b0};
        pushExp(5'h08, 1'b1, 3'd0, 512'h0, 32'd4, 1'b1, 3'b000);
        applyStimulus(v);

        // Full line with gaps between beats.
        v = '{addr:44'h0_0000_2040, snoop:4'b0111, toReg:32'd0, acWait:0, crDelay:0,
              crResp:5'b00101, nBeats:4, lastIdx:3, gap:1'b1};
        pushExp(5'h05, 1'b1, 3'd4, fullLine, 32'd2, 1'b1, 3'b000);
        applyStimulus(v);

        // AC backpressure for 10 cycles with a short timeout that must not apply.
        v = '{addr:44'hABC_DEF0_1234, snoop:4'b1010, toReg:32'd2, acWait:10, crDelay:0,
              crResp:5'b00000, nBeats:0, lastIdx:-1, gap:1'b0};
        pushExp(5'h00, 1'b1, 3'd0, 512'h0, 32'd12, 1'b1, 3'b000);
        applyStimulus(v);

        // Early cdlast on beat 1.
        v = '{addr:44'h0_0000_3000, snoop:4'b0001, toReg:32'd0, acWait:0, crDelay:1,
              crResp:5'b00001, nBeats:2, lastIdx:1, gap:1'b0};
        pushExp(5'h01, 1'b1, 3'd2, halfLine, 32'd3, 1'b1, 3'b010);
        applyStimulus(v);

        // Missing cdlast: a fifth beat is offered but must not be taken.
        v = '{addr:44'h0_0000_4000, snoop:4'b0001, toReg:32'd0, acWait:0, crDelay:0,
              crResp:5'b00001, nBeats:5, lastIdx:-1, gap:1'b0};
        pushExp(5'h01, 1'b1, 3'd4, fullLine, 32'd2, 1'b1, 3'b100);
        applyStimulus(v);

        // CR never arrives: timeout after 5 cycles in CR_WAIT.
        v = '{addr:44'h0_0000_5000, snoop:4'b0011, toReg:32'd5, acWait:0, crDelay:-1,
              crResp:5'b00000, nBeats:0, lastIdx:-1, gap:1'b0};
        pushExp(5'h00, 1'b0, 3'd0, 512'h0, 32'd0, 1'b0, 3'b001);
        applyStimulus(v);

        // CR arrives exactly in the timeout cycle: handshake wins.
        v = '{addr:44'h0_0000_6000, snoop:4'b0011, toReg:32'd5, acWait:0, crDelay:4,
              crResp:5'b10000, nBeats:0, lastIdx:-1, gap:1'b0};
        pushExp(5'h10, 1'b1, 3'd0, 512'h0, 32'd6, 1'b1, 3'b000);
        applyStimulus(v);

        // Start during CR_WAIT is ignored and not queued.
        i_timeout_reg = 32'd0;
        startSnoop(44'h0_0000_7000, 4'b0010);
        i_acready = 1'b1;
        tick();
        i_acready = 1'b0;
        i_start   = 1'b1;
        i_acaddr  = 44'hFFF_FFFF_FFFF;
        tick();
        i_start   = 1'b0;
        checkOutput("ignoredStartAddr", 512'(o_acaddr), 512'(44'h0_0000_7000));
        checkOutput("ignoredStartCrready", 512'(o_crready), 512'(1));
        pushExp(5'h08, 1'b1, 3'd0, 512'h0, 32'd3, 1'b1, 3'b000);
        i_crvalid = 1'b1;
        i_crresp  = 5'b01000;
        tick();
        i_crvalid = 1'b0;
        waitIdle();
        repeat (3) tick();
        checkOutput("noQueuedStartAcvalid", 512'(o_acvalid), 512'(0));
        checkOutput("noQueuedStartBusy", 512'(o_busy), 512'(0));

        // Reset during the third CD beat abandons the transaction.
        startSnoop(44'h123_4567_89AB, 4'b1011);
        i_acready = 1'b1;
        tick();
        i_acready = 1'b0;
        i_crvalid = 1'b1;
        i_crresp  = 5'b00001;
        tick();
        i_crvalid = 1'b0;
        for (int b = 0; b < 2; b++) begin
            i_cdvalid = 1'b1;
            i_cddata  = beatData(b);
            tick();
        end
        i_cddata   = beatData(2);
        ace_areset = 1'b1;
        tick();
        ace_areset = 1'b0;
        i_cdvalid  = 1'b0;
        checkAllZero("midReset");
        tick();
        checkOutput("postResetBusy", 512'(o_busy), 512'(0));

        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

endmodule

// File: doc/ace_snoop_initiator.md
Name: ace_snoop_initiator

Overview:
- Snoop-issuing master for the ACE snoop channels (AC out, CR/CD in). It is the counterpart of the devil_in_fpga snoop responder.
- Software or a test sequencer programs an AC snoop (address, ACSNOOP) and pulses start. The block drives the AC handshake, collects the CR response and any CD cache-line data, and reports the result, response latency and error flags.
- It sits between the AXI-Lite register block and the ACE snoop port of the device under attack or test. It is used for stimulating responders in-system and for measuring their delay behaviour.

Parameters:
- C_ACE_DATA_WIDTH, 128, CD data width in bits.
- C_ACE_ADDR_WIDTH, 44, AC address width in bits.
- C_LINE_BEATS, 4, CD beats per cache line (64 B line at 128 bit).
- C_CNT_WIDTH, 32, width of the latency and timeout counters.

Ports:
- ace_aclk  in  1  clock.
- ace_areset  in  1  synchronous, active-high reset.
- i_start  in  1  one-cycle request to issue a snoop.
- i_acaddr  in  C_ACE_ADDR_WIDTH  snoop address, latched on accepted start.
- i_acsnoop  in  4  snoop type, latched on accepted start.
- i_timeout_reg  in  C_CNT_WIDTH  CR/CD timeout in cycles; 0 disables the timeout.
- o_acvalid  out  1  AC valid.
- o_acaddr  out  C_ACE_ADDR_WIDTH  AC address.
- o_acsnoop  out  4  AC snoop type.
- o_acprot  out  3  AC protection; constant 3'b000.
- i_acready  in  1  AC ready.
- i_crvalid  in  1  CR valid.
- i_crresp  in  5  CR response: [0] DataTransfer, [1] Error, [2] PassDirty, [3] IsShared, [4] WasUnique.
- o_crready  out  1  CR ready.
- i_cdvalid  in  1  CD valid.
- i_cddata  in  C_ACE_DATA_WIDTH  CD data.
- i_cdlast  in  1  CD last.
- o_cdready  out  1  CD ready.
- o_busy  out  1  high while not in IDLE.
- o_done  out  1  one-cycle completion pulse.
- o_crresp  out  5  captured CR response.
- o_line_data  out  C_ACE_DATA_WIDTH*C_LINE_BEATS  captured line; beat k occupies [k*W +: W].
- o_beats  out  $clog2(C_LINE_BEATS)+1  number of CD beats received.
- o_latency  out  C_CNT_WIDTH  cycles from first o_acvalid cycle to the CR handshake; saturating.
- o_error  out  3  [0] timeout, [1] early cdlast, [2] missing cdlast.

Behaviour:
- All outputs are registered.
- Reset (ace_areset=1, sampled on the rising edge):
  - state returns to IDLE;
  - every output is 0, including o_line_data, o_latency and o_error;
  - an in-flight transaction is abandoned, even if o_acvalid was high.
- State machine: IDLE -> AC_REQ -> CR_WAIT -> [CD_WAIT] -> DONE -> IDLE.
- IDLE:
  - i_start=1 latches i_acaddr/i_acsnoop, clears o_error/o_beats/o_line_data/o_latency and moves to AC_REQ.
  - o_acvalid rises in the cycle after start, i.e. start-to-acvalid latency is 1 cycle.
  - i_start in any non-IDLE state, including DONE, is ignored with no queueing.
- AC_REQ:
  - o_acvalid=1; o_acaddr and o_acsnoop are held stable until i_acready=1.
  - The latency counter increments every cycle from the first acvalid cycle.
  - The AC handshake is never aborted: no timeout applies in this state, per the AXI valid rule.
  - On the handshake, o_acvalid=0 next cycle and the state moves to CR_WAIT.
- CR_WAIT:
  - o_crready=1.
  - On i_crvalid: capture i_crresp into o_crresp and freeze o_latency, then drop o_crready.
  - If i_crresp[0]=1, go to CD_WAIT; otherwise go to DONE.
- CD_WAIT:
  - o_cdready=1.
  - Each i_cdvalid beat stores i_cddata into slot o_beats, then o_beats increments.
  - i_cdlast on beat C_LINE_BEATS-1 goes to DONE cleanly.
  - i_cdlast on an earlier beat sets o_error[1] and goes to DONE.
  - Beat C_LINE_BEATS-1 without i_cdlast sets o_error[2] and goes to DONE; later beats are not accepted.
- Timeout:
  - When i_timeout_reg≠0, a counter runs during CR_WAIT and CD_WAIT; it is cleared on entry to CR_WAIT.
  - When the count reaches i_timeout_reg, the block sets o_error[0], drops ready and goes to DONE.
  - A handshake in the same cycle the timeout is reached takes priority: data is captured and no timeout is flagged.
- DONE: o_done=1 for exactly one cycle, o_busy=0 next cycle, then IDLE. Captured results hold until the next accepted start.
- o_latency saturates at all-ones and does not wrap.
- o_busy=1 in AC_REQ, CR_WAIT, CD_WAIT and DONE.

Test Plan:
- **Clean snoop, no data:** start with acaddr=0x1000, acsnoop=4'b0001; i_acready=1 immediately; CR arrives 3 cycles later with crresp=5'b01000 -> o_acvalid high 1 cycle, o_crresp=0x08, o_beats=0, o_latency=4, o_done pulse, o_error=0.
- **Data transfer:** crresp=5'b00101, then 4 CD beats 0xA..,0xB..,0xC..,0xD.. with cdlast on beat 3, cdvalid toggled between beats -> o_line_data slots 0..3 match in order, o_beats=4, o_error=0.
- **AC backpressure:** i_acready held low 10 cycles with i_timeout_reg=2 -> o_acvalid, o_acaddr and o_acsnoop stay stable, no timeout, completes normally after acready.
- **CD protocol errors:** cdlast on beat 1 -> o_error=3'b010, o_beats=2. Separately, no cdlast through beat 3 -> o_error=3'b100, o_beats=4.
- **Timeout and collision:**
  - i_timeout_reg=5 with crvalid never asserted -> o_error[0]=1, o_done 5 cycles after CR_WAIT entry, o_crready low after.
  - crvalid arriving exactly on cycle 5 -> captured, o_error=0.
- **Reset mid-CD and ignored start:** ace_areset asserted during beat 2 -> next cycle all outputs 0, state IDLE. i_start issued during CR_WAIT -> ignored, and o_acaddr is unchanged.
